// File: rtl/multicycle_control_unit_if.sv
// Handshake/control bundle between the multi-cycle control unit (master) and
// the memories plus shared datapath (slave).
interface multicycle_control_unit_if #(
    parameter int CNT_W = 32
);
    logic [31:0]      instr;
    logic             imem_ready;
    logic             dmem_ready;
    logic             zero;
    logic             lt;
    logic             ltu;
    logic             imem_req;
    logic             dmem_req;
    logic             memwrite;
    logic             ir_write;
    logic             pc_write;
    logic [1:0]       pc_src;
    logic             regwrite;
    logic             mem2reg;
    logic             alusrc;
    logic [3:0]       aluctl;
    logic             is_lui;
    logic             is_jal;
    logic             is_jalr;
    logic             is_auipc;
    logic             trap;
    logic [CNT_W-1:0] retire_cnt;

    modport master (
        input  instr, imem_ready, dmem_ready, zero, lt, ltu,
        output imem_req, dmem_req, memwrite, ir_write, pc_write, pc_src, regwrite,
               mem2reg, alusrc, aluctl, is_lui, is_jal, is_jalr, is_auipc, trap, retire_cnt
    );

    modport slave (
        output instr, imem_ready, dmem_ready, zero, lt, ltu,
        input  imem_req, dmem_req, memwrite, ir_write, pc_write, pc_src, regwrite,
               mem2reg, alusrc, aluctl, is_lui, is_jal, is_jalr, is_auipc, trap, retire_cnt
    );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB with memory timeout and trap.
// Optional retired-instruction counter enabled by defining RETIRE_CNT_EN.
module multicycle_control_unit #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input logic                       clk,
    input logic                       rst_n,
    multicycle_control_unit_if.master bus
);
    localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    localparam logic [3:0] ALU_AND  = 4'd0;
    localparam logic [3:0] ALU_OR   = 4'd1;
    localparam logic [3:0] ALU_ADD  = 4'd2;
    localparam logic [3:0] ALU_SUB  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_XOR  = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP} state_t;

    typedef struct packed {
        logic       illegal;
        logic       load;
        logic       store;
        logic       branch;
        logic       jal;
        logic       jalr;
        logic       lui;
        logic       auipc;
        logic       mem2reg;
        logic       alusrc;
        logic [2:0] funct3;
        logic [3:0] aluctl;
    } dec_t;

    state_t            state, state_nx;
    dec_t              dec_d, dec_q;
    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic              f7b5;
    logic [3:0]        alu_base;
    logic [WAIT_W-1:0] wait_cnt;
    logic              timeout;
    logic              taken;
    logic              imem_req_c, dmem_req_c, memwrite_c, ir_write_c, pc_write_c, regwrite_c;
    logic [1:0]        pc_src_c;
    logic              unused_instr_bits;

    assign opcode = bus.instr[6:0];
    assign funct3 = bus.instr[14:12];
    assign f7b5   = bus.instr[30];
    assign unused_instr_bits = ^{bus.instr[31], bus.instr[29:15], bus.instr[11:7]};

    always_comb begin
        alu_base = ALU_ADD;
        case (funct3)
            3'b000: alu_base = ALU_ADD;
            3'b001: alu_base = ALU_SLL;
            3'b010: alu_base = ALU_SLT;
            3'b011: alu_base = ALU_SLTU;
            3'b100: alu_base = ALU_XOR;
            3'b101: alu_base = f7b5 ? ALU_SRA : ALU_SRL;
            3'b110: alu_base = ALU_OR;
            default: alu_base = ALU_AND;
        endcase
    end

    always_comb begin
        dec_d        = '0;
        dec_d.funct3 = funct3;
        dec_d.aluctl = ALU_ADD;
        case (opcode)
            7'h33: dec_d.aluctl = (funct3 == 3'b000 && f7b5) ? ALU_SUB : alu_base;
            7'h13: begin
                dec_d.aluctl = alu_base;
                dec_d.alusrc = 1'b1;
            end
            7'h03: begin
                dec_d.load    = 1'b1;
                dec_d.mem2reg = 1'b1;
                dec_d.alusrc  = 1'b1;
            end
            7'h23: begin
                dec_d.store  = 1'b1;
                dec_d.alusrc = 1'b1;
            end
            7'h63: begin
                dec_d.branch  = 1'b1;
                dec_d.aluctl  = ALU_SUB;
                dec_d.illegal = (funct3[2:1] == 2'b01);
            end
            7'h6F: begin
                dec_d.jal    = 1'b1;
                dec_d.alusrc = 1'b1;
            end
            7'h67: begin
                dec_d.jalr   = 1'b1;
                dec_d.alusrc = 1'b1;
            end
            7'h37: begin
                dec_d.lui    = 1'b1;
                dec_d.alusrc = 1'b1;
            end
            7'h17: begin
                dec_d.auipc  = 1'b1;
                dec_d.alusrc = 1'b1;
            end
            default: dec_d.illegal = 1'b1;
        endcase
    end

    // Decode is captured alongside the IR so the datapath sees it from DECODE on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          dec_q <= '0;
        else if (ir_write_c) dec_q <= dec_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_FETCH;
        else        state <= state_nx;
    end

    // Counts consecutive non-ready cycles; any ready or non-waiting state clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            wait_cnt <= '0;
        else if ((state == S_FETCH && !bus.imem_ready) || (state == S_MEM && !bus.dmem_ready))
            wait_cnt <= wait_cnt + WAIT_W'(1);
        else
            wait_cnt <= '0;
    end

    assign timeout = (wait_cnt == WAIT_LAST);

    always_comb begin
        taken = 1'b0;
        case (dec_q.funct3)
            3'b000: taken = bus.zero;
            3'b001: taken = !bus.zero;
            3'b100: taken = bus.lt;
            3'b101: taken = !bus.lt;
            3'b110: taken = bus.ltu;
            3'b111: taken = !bus.ltu;
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        state_nx   = state;
        imem_req_c = 1'b0;
        dmem_req_c = 1'b0;
        memwrite_c = 1'b0;
        ir_write_c = 1'b0;
        pc_write_c = 1'b0;
        regwrite_c = 1'b0;
        pc_src_c   = 2'd0;
        case (state)
            S_FETCH: begin
                imem_req_c = 1'b1;
                if (bus.imem_ready) begin
                    ir_write_c = 1'b1;
                    state_nx   = S_DECODE;
                end else if (timeout) begin
                    state_nx = S_TRAP;
                end
            end
            S_DECODE: state_nx = dec_q.illegal ? S_TRAP : S_EXEC;
            S_EXEC: begin
                if (dec_q.branch) begin
                    pc_write_c = 1'b1;
                    pc_src_c   = taken ? 2'd1 : 2'd0;
                    state_nx   = S_FETCH;
                end else if (dec_q.load || dec_q.store) begin
                    state_nx = S_MEM;
                end else begin
                    state_nx = S_WB;
                end
            end
            S_MEM: begin
                dmem_req_c = 1'b1;
                memwrite_c = dec_q.store;
                if (bus.dmem_ready) begin
                    if (dec_q.store) begin
                        pc_write_c = 1'b1;
                        state_nx   = S_FETCH;
                    end else begin
                        state_nx = S_WB;
                    end
                end else if (timeout) begin
                    state_nx = S_TRAP;
                end
            end
            S_WB: begin
                regwrite_c = 1'b1;
                pc_write_c = 1'b1;
                pc_src_c   = dec_q.jal ? 2'd1 : (dec_q.jalr ? 2'd2 : 2'd0);
                state_nx   = S_FETCH;
            end
            default: state_nx = S_TRAP;
        endcase
    end

    // Strobes are gated by rst_n so they drop immediately when reset asserts.
    assign bus.imem_req = imem_req_c & rst_n;
    assign bus.dmem_req = dmem_req_c & rst_n;
    assign bus.memwrite = memwrite_c & rst_n;
    assign bus.ir_write = ir_write_c & rst_n;
    assign bus.pc_write = pc_write_c & rst_n;
    assign bus.regwrite = regwrite_c & rst_n;
    assign bus.pc_src   = pc_src_c & {2{rst_n}};
    assign bus.trap     = (state == S_TRAP);
    assign bus.mem2reg  = dec_q.mem2reg;
    assign bus.alusrc   = dec_q.alusrc;
    assign bus.aluctl   = dec_q.aluctl;
    assign bus.is_lui   = dec_q.lui;
    assign bus.is_jal   = dec_q.jal;
    assign bus.is_jalr  = dec_q.jalr;
    assign bus.is_auipc = dec_q.auipc;

`ifdef RETIRE_CNT_EN
    logic [CNT_W-1:0] retire_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          retire_q <= '0;
        else if (pc_write_c) retire_q <= retire_q + CNT_W'(1);
    end

    assign bus.retire_cnt = retire_q;
`else
    assign bus.retire_cnt = {CNT_W{1'b0}};
`endif
endmodule
